// File: rtl/pe_casc_ctrl_pkg.sv
// Shared types and constants for the PE cascade controller and its decode stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pe_casc_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // DSP OPMODE values used by the Montgomery iteration
  localparam logic [6:0] OP_M    = 7'h05;  // P = A*B
  localparam logic [6:0] OP_MC   = 7'h35;  // P = A*B + C
  localparam logic [6:0] OP_ZERO = 7'h00;  // P held at zero / idle

  // Multiplexer select value for a PE that is not being driven
  localparam logic [1:0] SEL_IDLE = 2'd3;

  // Complete control word for one PE cycle
  typedef struct packed {
    logic       a_reg_en;
    logic       m_reg_en;
    logic       creg_en;
    logic       res_delay_en;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic [1:0] mux_c_sel;
    logic [6:0] opmode;
  } ctrl_t;

  // Quiescent control word: every enable low, every select parked
  localparam ctrl_t CTRL_IDLE = '{
    a_reg_en:     1'b0,
    m_reg_en:     1'b0,
    creg_en:      1'b0,
    res_delay_en: 1'b0,
    mux_a_sel:    SEL_IDLE,
    mux_b_sel:    SEL_IDLE,
    mux_c_sel:    SEL_IDLE,
    opmode:       OP_ZERO
  };

  // Pipeline depth of the PE multiplier path: input stage plus optional A/B and M registers
  function automatic int reg_level(input int abreg, input int mreg);
    return 1 + abreg + mreg;
  endfunction

endpackage

// File: rtl/pe_casc_ctrl_decode.sv
// Maps the (next) controller state, phase count and first-iteration flag to a PE control word.
// Latency: purely combinational; the top module registers the result.
// Backpressure: none; the decode is a pure function of its inputs.
module pe_casc_ctrl_decode
  import pe_casc_ctrl_pkg::*;
#(
  parameter int L     = 3,
  parameter int CNT_W = 4
) (
  input  state_e             state,
  input  logic [CNT_W-1:0]   cnt,
  input  logic               first_iter,
  output ctrl_t              ctrl
);

  // Phase positions inside one iteration; each later step waits one PE pipeline depth
  localparam logic [CNT_W-1:0] PH_LOAD = '0;                // fetch a word
  localparam logic [CNT_W-1:0] PH_AB   = CNT_W'(1);         // a*b (+ t)
  localparam logic [CNT_W-1:0] PH_TP   = CNT_W'(1 + L);     // t0*p'
  localparam logic [CNT_W-1:0] PH_MP   = CNT_W'(1 + 2 * L); // m*p + t

  // Only RUN produces activity; everything else parks the PE
  always_comb begin
    ctrl = CTRL_IDLE;
    if (state == ST_RUN) begin
      case (cnt)
        PH_LOAD: begin
          ctrl.a_reg_en = 1'b1;
        end
        PH_AB: begin
          ctrl.mux_a_sel = 2'd0;
          ctrl.mux_b_sel = 2'd0;
          if (first_iter) begin
            // no running sum yet: plain product, C path parked
            ctrl.mux_c_sel = 2'd3;
            ctrl.opmode    = OP_M;
          end else begin
            // accumulate onto the previous iteration's result
            ctrl.mux_c_sel = 2'd0;
            ctrl.opmode    = OP_MC;
            ctrl.creg_en   = 1'b1;
          end
        end
        PH_TP: begin
          ctrl.mux_a_sel    = 2'd1;
          ctrl.mux_b_sel    = 2'd1;
          ctrl.opmode       = OP_M;
          ctrl.res_delay_en = 1'b1;
        end
        PH_MP: begin
          ctrl.mux_a_sel = 2'd1;
          ctrl.mux_b_sel = 2'd2;
          ctrl.mux_c_sel = 2'd1;
          ctrl.opmode    = OP_MC;
          ctrl.creg_en   = 1'b1;
          ctrl.m_reg_en  = 1'b1;
        end
        default: begin
          ctrl = CTRL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/pe_casc_ctrl.sv
// Sequences one Montgomery multiplication over S operand words on a cascaded DSP PE.
// Latency: done_o pulses S*T+L+1 cycles after the edge that accepts start_i; all outputs registered.
// Backpressure: none; start_i is only sampled in IDLE and is dropped (not queued) while busy.
module pe_casc_ctrl
  import pe_casc_ctrl_pkg::*;
#(
  parameter int S     = 16,
  parameter int ABREG = 1,
  parameter int MREG  = 1
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [$clog2(S)-1:0] a_addr_o,
  output logic                 a_reg_en_o,
  output logic                 m_reg_en_o,
  output logic                 CREG_en_o,
  output logic                 RES_delay_en_o,
  output logic [1:0]           mux_A_sel_o,
  output logic [1:0]           mux_B_sel_o,
  output logic [1:0]           mux_C_sel_o,
  output logic [6:0]           OPMODE_o
);

  localparam int L     = reg_level(ABREG, MREG);
  localparam int T     = 3 * L + 1;
  localparam int CNT_W = $clog2(T);
  localparam int IDX_W = $clog2(S);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(T - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(L - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(S - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  ctrl_t              ctrl_d, ctrl_q;
  logic [IDX_W-1:0]   addr_q;
  logic               busy_q;
  logic               done_q;

  // State, phase counter and iteration index
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: T-cycle iterations in RUN, L-cycle drain in FLUSH, one DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_FLUSH;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FLUSH: begin
        // cnt is reused to count out the last result leaving the PE pipeline
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Control word decoded from the next-state values so the registered outputs line up with state
  pe_casc_ctrl_decode #(
    .L     (L),
    .CNT_W (CNT_W)
  ) u_decode (
    .state      (state_d),
    .cnt        (cnt_d),
    .first_iter (idx_d == '0),
    .ctrl       (ctrl_d)
  );

  // Output registers; the address only moves when a new a word is fetched
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ctrl_q <= CTRL_IDLE;
      addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      if (state_d == ST_RUN && cnt_d == '0) begin
        addr_q <= idx_d;
      end
      // busy stays up through the done pulse, which trails the DONE state by one cycle
      busy_q <= (state_d != ST_IDLE) || (state_q == ST_DONE);
      done_q <= (state_q == ST_DONE);
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign a_addr_o       = addr_q;
  assign a_reg_en_o     = ctrl_q.a_reg_en;
  assign m_reg_en_o     = ctrl_q.m_reg_en;
  assign CREG_en_o      = ctrl_q.creg_en;
  assign RES_delay_en_o = ctrl_q.res_delay_en;
  assign mux_A_sel_o    = ctrl_q.mux_a_sel;
  assign mux_B_sel_o    = ctrl_q.mux_b_sel;
  assign mux_C_sel_o    = ctrl_q.mux_c_sel;
  assign OPMODE_o       = ctrl_q.opmode;

endmodule
